// File: rtl/sblock_cfg_loader_pkg.sv
// Shared types and widths for the switch-block configuration loader.
package sblock_cfg_pkg;

   localparam int unsigned SB_CFG_W = 18;
   localparam int unsigned SB_H_W   = 9;
   localparam int unsigned SB_V_W   = 9;

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, DONE} sbcfg_state_t;

   typedef logic [SB_CFG_W-1:0] sb_cfg_word_t;

   // Rotate-left-and-xor fold used by the optional load checksum.
   function automatic sb_cfg_word_t chk_step(input sb_cfg_word_t acc, input sb_cfg_word_t word);
      return {acc[SB_CFG_W-2:0], acc[SB_CFG_W-1]} ^ word;
   endfunction

endpackage

// File: rtl/sblock_cfg_loader_if.sv
// Valid/ready stream carrying one configuration word per switch block.
interface sblock_cfg_loader_if;
   import sblock_cfg_pkg::*;

   logic         cfg_valid;
   logic         cfg_ready;
   sb_cfg_word_t cfg_data;

   modport master (output cfg_valid, output cfg_data, input  cfg_ready);
   modport slave  (input  cfg_valid, input  cfg_data, output cfg_ready);

endinterface

// File: rtl/sblock_cfg_loader.sv
// Loads one 18-bit word per switch block with setup/strobe/hold margins on a shared bus.
// Optional build macro SBLOCK_CFG_CHK_EN adds a running checksum output chk.
module sblock_cfg_loader
   import sblock_cfg_pkg::*;
#(
   parameter int unsigned N_SB      = 16,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1,
   localparam int unsigned IDX_W    = (N_SB > 1) ? $clog2(N_SB) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   sblock_cfg_loader_if.slave  cfg,
   output sb_cfg_word_t        sb_bits,
   output logic [N_SB-1:0]     sb_wr_en,
   output logic                busy,
   output logic                done,
   output logic [IDX_W-1:0]    cur_idx
`ifdef SBLOCK_CFG_CHK_EN
   ,
   output sb_cfg_word_t        chk
`endif
);

   localparam int unsigned MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SB - 1);

   sbcfg_state_t     state;
   logic [CNT_W-1:0] cnt;

   // Single FSM; every output is updated alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         sb_bits       <= '0;
         sb_wr_en      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         cur_idx       <= '0;
         cfg.cfg_ready <= 1'b0;
`ifdef SBLOCK_CFG_CHK_EN
         chk           <= '0;
`endif
      end else if (abort && (state != IDLE)) begin
         // sb_bits is kept; the aborted block may hold a partial value.
         state         <= IDLE;
         cnt           <= '0;
         sb_wr_en      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         cur_idx       <= '0;
         cfg.cfg_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state         <= LOAD;
                  cur_idx       <= '0;
                  busy          <= 1'b1;
                  cfg.cfg_ready <= 1'b1;
`ifdef SBLOCK_CFG_CHK_EN
                  chk           <= '0;
`endif
               end
            end
            LOAD: begin
               if (cfg.cfg_valid && cfg.cfg_ready) begin
                  sb_bits       <= cfg.cfg_data;
                  cnt           <= CNT_W'(SETUP_CYC - 1);
                  state         <= SETUP;
                  cfg.cfg_ready <= 1'b0;
`ifdef SBLOCK_CFG_CHK_EN
                  chk           <= chk_step(chk, cfg.cfg_data);
`endif
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  cnt      <= CNT_W'(PULSE_CYC - 1);
                  state    <= STROBE;
                  sb_wr_en <= N_SB'(1) << cur_idx;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  cnt      <= CNT_W'(HOLD_CYC - 1);
                  state    <= HOLD;
                  sb_wr_en <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  if (cur_idx == LAST_IDX) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     cur_idx       <= cur_idx + IDX_W'(1);
                     state         <= LOAD;
                     cfg.cfg_ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               // A start seen here is dropped: the loader only listens in IDLE.
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Scoreboard bench: driver pushes expected strobes, negedge monitor pops and checks them.
module tb_sblock_cfg_loader;
   import sblock_cfg_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned PULSE = 2;

   typedef struct packed {
      logic [1:0]   idx;
      sb_cfg_word_t w;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   sb_cfg_word_t sb_bits;
   logic [N-1:0] sb_wr_en;
   logic         busy, done;
   logic [1:0]   cur_idx;
`ifdef SBLOCK_CFG_CHK_EN
   sb_cfg_word_t chk;
`endif

   sblock_cfg_loader_if cfg ();

   sblock_cfg_loader #(.N_SB(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .cfg      (cfg),
      .sb_bits  (sb_bits),
      .sb_wr_en (sb_wr_en),
      .busy     (busy),
      .done     (done),
      .cur_idx  (cur_idx)
`ifdef SBLOCK_CFG_CHK_EN
      ,
      .chk      (chk)
`endif
   );

   always #5 clk = ~clk;

   int           n_chk  = 0;
   int           n_fail = 0;
   exp_t         exp_q[$];
   sb_cfg_word_t lat[N];
   int           done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: strobe scoreboard, bus timing invariants and a model of the block latches.
   sb_cfg_word_t prev_bits = '0, strobe_bits = '0;
   logic [N-1:0] prev_wr = '0;
   int           width = 0;
   always @(negedge clk) begin
      exp_t e;
      if (sb_bits !== prev_bits) begin
         check("wr_en low on bus change", {60'd0, sb_wr_en}, 64'd0);
         check("wr_en low before bus change", {60'd0, prev_wr}, 64'd0);
      end
      if (sb_wr_en != '0) check("wr_en onehot", 64'($countones(sb_wr_en) <= 1), 64'd1);
      if (sb_wr_en != '0 && prev_wr == '0) begin
         check("setup margin", 64'(sb_bits), 64'(prev_bits));
         if (exp_q.size() == 0) begin
            check("unexpected strobe", 64'(sb_wr_en), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("strobe target", 64'(sb_wr_en), 64'(4'd1 << e.idx));
            check("strobe word", 64'(sb_bits), 64'(e.w));
         end
         width       = 1;
         strobe_bits = sb_bits;
      end else if (sb_wr_en != '0) begin
         width++;
         check("bus stable in strobe", 64'(sb_bits), 64'(strobe_bits));
      end else if (prev_wr != '0) begin
         check("strobe width", 64'(width), 64'(PULSE));
         check("hold margin", 64'(sb_bits), 64'(strobe_bits));
      end
      for (int i = 0; i < N; i++) if (sb_wr_en[i]) lat[i] = sb_bits;
      if (done) done_cnt++;
      prev_bits = sb_bits;
      prev_wr   = sb_wr_en;
   end

   function automatic sb_cfg_word_t chk_model(input logic [3:0][17:0] w);
      sb_cfg_word_t a = '0;
      for (int i = 0; i < 4; i++) a = {a[16:0], a[17]} ^ w[i];
      return a;
   endfunction

   // Caller is just past a negedge; returns just past the negedge after the handshake.
   task automatic send_word(input sb_cfg_word_t w, input logic [1:0] idx);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_data  = w;
      for (int t = 0; t < 100; t++) begin
         if (cfg.cfg_ready) begin
            @(negedge clk);
            exp_q.push_back({idx, w});
            return;
         end
         @(negedge clk);
      end
      check("handshake timeout", 64'd1, 64'd0);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done;
      int c = 0;
      while (!done && c < 200) begin @(negedge clk); c++; end
      check("done seen", 64'(done), 64'd1);
   endtask

   task automatic check_blocks(input logic [3:0][17:0] w, input string tag);
      for (int i = 0; i < N; i++) check(tag, 64'(lat[i]), 64'(w[i]));
   endtask

   // Full load with valid held high; checks done latency, checksum and final contents.
   task automatic run_load(input logic [3:0][17:0] w, input string tag);
      int d0 = done_cnt;
      pulse_start();
      fork
         begin
            for (int i = 0; i < N; i++) send_word(w[i], 2'(i));
            cfg.cfg_valid = 1'b0;
         end
         begin
            int c = 1;
            while (!done && c < 200) begin @(negedge clk); c++; end
            check("done latency", 64'(c), 64'd21);
`ifdef SBLOCK_CFG_CHK_EN
            check("chk at done", 64'(chk), 64'(chk_model(w)));
`endif
         end
      join
      @(negedge clk);
      check("busy after done", 64'(busy), 64'd0);
      check("one done pulse", 64'(done_cnt - d0), 64'd1);
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      check_blocks(w, tag);
   endtask

   logic [3:0][17:0] wa, wb, wc;
   sb_cfg_word_t     w_keep;
   int               d_before;

   initial begin
      wa = {18'h15555, 18'h2AAAA, 18'h00000, 18'h3FFFF};
      wb = {18'h3C3C3, 18'h0ABCD, 18'h12345, 18'h00001};
      wc = {18'h00008, 18'h00004, 18'h00002, 18'h00001};
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg.cfg_valid = 1'b0; cfg.cfg_data = '0;
      @(negedge clk);
      check("reset sb_bits", 64'(sb_bits), 64'd0);
      check("reset wr_en", 64'(sb_wr_en), 64'd0);
      check("reset busy/done/ready", {61'd0, busy, done, cfg.cfg_ready}, 64'd0);
      check("reset cur_idx", 64'(cur_idx), 64'd0);
      rst = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort in idle", {62'd0, busy, cfg.cfg_ready}, 64'd0);

      run_load(wa, "block contents");

      // Bubble of 7 cycles while the loader waits in LOAD for word 2.
      pulse_start();
      send_word(wb[0], 2'd0);
      send_word(wb[1], 2'd1);
      cfg.cfg_valid = 1'b0;
      for (int t = 0; t < 50 && !cfg.cfg_ready; t++) @(negedge clk);
      for (int k = 0; k < 7; k++) begin
         check("bubble ready", 64'(cfg.cfg_ready), 64'd1);
         check("bubble wr_en", 64'(sb_wr_en), 64'd0);
         check("bubble bus", 64'(sb_bits), 64'(wb[1]));
         @(negedge clk);
      end
      send_word(wb[2], 2'd2);
      send_word(wb[3], 2'd3);
      cfg.cfg_valid = 1'b0;
      wait_done();
      @(negedge clk);
      check_blocks(wb, "bubble contents");

      // Abort in the second strobe cycle of block 1.
      pulse_start();
      send_word(wa[0], 2'd0);
      send_word(wa[1], 2'd1);
      cfg.cfg_valid = 1'b0;
      for (int t = 0; t < 50 && sb_wr_en != 4'b0010; t++) @(negedge clk);
      @(negedge clk);
      check("abort strobe cycle 2", 64'(sb_wr_en), 64'h2);
      d_before = done_cnt;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort wr_en", 64'(sb_wr_en), 64'd0);
      check("abort busy/ready", {62'd0, busy, cfg.cfg_ready}, 64'd0);
      check("abort cur_idx", 64'(cur_idx), 64'd0);
      check("abort keeps bus", 64'(sb_bits), 64'(wa[1]));
      repeat (3) @(negedge clk);
      check("abort no done", 64'(done_cnt - d_before), 64'd0);
      run_load(wb, "reload contents");

      // Start while busy, then start in the DONE cycle: both ignored.
      pulse_start();
      send_word(wa[0], 2'd0);
      pulse_start();
      send_word(wa[1], 2'd1);
      check("cur_idx after busy start", 64'(cur_idx), 64'd1);
      send_word(wa[2], 2'd2);
      send_word(wa[3], 2'd3);
      cfg.cfg_valid = 1'b0;
      wait_done();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start in done ignored", {62'd0, busy, cfg.cfg_ready}, 64'd0);
      @(negedge clk);
      check("still idle", 64'(busy), 64'd0);
      check_blocks(wa, "busy-start contents");

      // Reset during HOLD of block 0.
      pulse_start();
      send_word(wc[3], 2'd0);
      cfg.cfg_valid = 1'b0;
      for (int t = 0; t < 50 && sb_wr_en == '0; t++) @(negedge clk);
      for (int t = 0; t < 50 && sb_wr_en != '0; t++) @(negedge clk);
      w_keep = sb_bits;
      check("bus before rst", 64'(w_keep), 64'(wc[3]));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst bus cleared", 64'(sb_bits), 64'd0);
      check("rst wr_en", 64'(sb_wr_en), 64'd0);
      check("rst busy/done/ready", {61'd0, busy, done, cfg.cfg_ready}, 64'd0);
      check("rst cur_idx", 64'(cur_idx), 64'd0);

      run_load(wc, "power-of-two contents");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "timeout");
   end

endmodule
